// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI register bank.
package spi_reg_pkg;

    localparam int FRAME_LEN = 16;
    localparam int ADDR_W    = 7;
    localparam int RW_BIT    = 15;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [ADDR_W-1:0] STATUS_BASE = 7'h40;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(FRAME_LEN / 2);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_edge_detect.sv
// Registered copy of the synchronized SPI clock with chip-select gated edge strobes.
module spi_edge_detect (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    output logic rise,
    output logic fall
);

    logic sclk_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_q <= 1'b0;
        end else if (ena) begin
            sclk_q <= spi_sclk;
        end
    end

    assign rise = ena & spi_sclk & ~sclk_q & ~spi_cs_n;
    assign fall = ena & ~spi_sclk & sclk_q & ~spi_cs_n;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral: 16-bit frames addressing RW config bytes and RO status bytes.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter logic [7:0]  REG_RST  = 8'h00
) (
    input  logic                  rstb,
    input  logic                  clk,
    input  logic                  ena,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [8*NUM_REGS-1:0] status_i,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [ADDR_W-1:0]     wr_addr_o
);

    logic                  rise;
    logic                  fall;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_LEN-2:0]  rx_q;
    logic [7:0]            tx_q;
    logic [8*NUM_REGS-1:0] regs_q;
    logic                  stb_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    spi_state_t            state_q;
    spi_state_t            state_d;

    logic [FRAME_LEN-1:0]  frame;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data;
    logic [7:0]            rd_data;
    logic                  wr_hit;
    logic                  load_tx;
    logic                  shift_tx;
    logic                  commit_req;
    logic                  commit;

    spi_edge_detect u_edge (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .rise     (rise),
        .fall     (fall)
    );

    // The 16th bit is still on mosi when its rise is seen, so the commit
    // decodes the frame from the shift register plus the live input.
    assign frame   = {rx_q, spi_mosi};
    assign wr_addr = frame[FRAME_LEN-2 -: ADDR_W];
    assign wr_data = frame[7:0];
    assign rd_addr = rx_q[ADDR_W-1:0];

    always_comb begin
        rd_data = '0;
        wr_hit  = 1'b0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k))
                rd_data = regs_q[8*k +: 8];
            if (rd_addr == STATUS_BASE + ADDR_W'(k))
                rd_data = status_i[8*k +: 8];
            if (wr_addr == ADDR_W'(k))
                wr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        commit_req = 1'b0;
        if (spi_cs_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = ADDR;
                ADDR: begin
                    if (fall && cnt_q == CNT_HDR) begin
                        state_d = DATA;
                        load_tx = 1'b1;
                    end
                end
                DATA: begin
                    if (rise && cnt_q == CNT_LAST) begin
                        state_d    = DONE;
                        commit_req = frame[RW_BIT];
                    end else if (fall) begin
                        shift_tx = 1'b1;
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign commit = commit_req & wr_hit;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            regs_q    <= {NUM_REGS{REG_RST}};
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
        end else if (ena) begin
            stb_q <= 1'b0;
            if (spi_cs_n) begin
                cnt_q <= '0;
                tx_q  <= '0;
            end else if (rise && cnt_q < CNT_FULL) begin
                cnt_q <= cnt_q + 1'b1;
                rx_q  <= {rx_q[FRAME_LEN-3:0], spi_mosi};
            end
            if (load_tx)
                tx_q <= rd_data;
            else if (shift_tx)
                tx_q <= {tx_q[6:0], 1'b0};
            if (commit) begin
                stb_q     <= 1'b1;
                wr_addr_q <= wr_addr;
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (commit && wr_addr == ADDR_W'(k))
                    regs_q[8*k +: 8] <= wr_data;
            end
        end
    end

    assign spi_miso  = (state_q == DATA || state_q == DONE) ? tx_q[7] : 1'b0;
    assign regs_o    = regs_q;
    assign wr_stb_o  = stb_q & ena;
    assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed frame vectors for spi_reg_bank plus hand-written reset, enable and sampling sequences.
module tb_spi_reg_bank;

    localparam int HP = 5;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [31:0] status;
    logic [31:0] regs;
    logic        wr_stb;
    logic [6:0]  wr_addr;

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;

    spi_reg_bank #(.NUM_REGS(4), .REG_RST(8'h00)) dut (
        .rstb      (rstb),
        .clk       (clk),
        .ena       (ena),
        .spi_cs_n  (cs_n),
        .spi_sclk  (sclk),
        .spi_mosi  (mosi),
        .spi_miso  (miso),
        .status_i  (status),
        .regs_o    (regs),
        .wr_stb_o  (wr_stb),
        .wr_addr_o (wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) stb_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input int chg_at,
                             input logic [31:0] chg_val, input int ena_off,
                             output logic [7:0] rd);
        rd = '0;
        @(negedge clk) cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) status = chg_val;
            if (i == ena_off) ena = 1'b0;
            mosi = (i < 16) ? word[15 - i] : 1'b1;
            repeat (HP) @(negedge clk);
            if (i >= 8 && i < 16) rd = {rd[6:0], miso};
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
            if (i == ena_off) begin
                repeat (HP) @(negedge clk);
                ena = 1'b1;
            end
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        chk_rd;
        logic [7:0]  rd;
        int          stb;
        logic [31:0] regs;
        logic [6:0]  waddr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [7:0] rd;
        int         s0;

        vecs[0]  = '{16'h81A5, 16, 1'b1, 8'h00, 1, 32'h0000A500, 7'h01};
        vecs[1]  = '{16'h0100, 16, 1'b1, 8'hA5, 0, 32'h0000A500, 7'h01};
        vecs[2]  = '{16'h4000, 16, 1'b1, 8'h3C, 0, 32'h0000A500, 7'h01};
        vecs[3]  = '{16'h7F00, 16, 1'b1, 8'h00, 0, 32'h0000A500, 7'h01};
        vecs[4]  = '{16'h4300, 16, 1'b1, 8'h11, 0, 32'h0000A500, 7'h01};
        vecs[5]  = '{16'h4200, 16, 1'b1, 8'h22, 0, 32'h0000A500, 7'h01};
        vecs[6]  = '{16'h9055, 16, 1'b1, 8'h00, 0, 32'h0000A500, 7'h01};
        vecs[7]  = '{16'h83C3, 16, 1'b1, 8'h00, 1, 32'hC300A500, 7'h03};
        vecs[8]  = '{16'h8277, 12, 1'b0, 8'h00, 0, 32'hC300A500, 7'h03};
        vecs[9]  = '{16'h8266, 16, 1'b1, 8'h00, 1, 32'hC366A500, 7'h02};
        vecs[10] = '{16'h8012, 20, 1'b1, 8'h00, 1, 32'hC366A512, 7'h00};
        vecs[11] = '{16'h0300, 16, 1'b1, 8'hC3, 0, 32'hC366A512, 7'h00};
        vecs[12] = '{16'h0000, 16, 1'b1, 8'h12, 0, 32'hC366A512, 7'h00};
        vecs[13] = '{16'h8499, 16, 1'b1, 8'h00, 0, 32'hC366A512, 7'h00};
        vecs[14] = '{16'h4400, 16, 1'b1, 8'h00, 0, 32'hC366A512, 7'h00};
        vecs[15] = '{16'h0200, 16, 1'b1, 8'h66, 0, 32'hC366A512, 7'h00};

        rstb = 1'b0; ena = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        status = 32'h1122333C;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_regs", regs, 32'h0);
        chk("reset_miso", {31'b0, miso}, 32'h0);
        chk("reset_stb", {31'b0, wr_stb}, 32'h0);
        chk("reset_waddr", {25'b0, wr_addr}, 32'h0);

        for (int v = 0; v < 16; v++) begin
            s0 = stb_cnt;
            spi_frame(vecs[v].word, vecs[v].nbits, -1, status, -1, rd);
            if (vecs[v].chk_rd) chk($sformatf("vec%0d_rd", v), {24'b0, rd}, {24'b0, vecs[v].rd});
            chk($sformatf("vec%0d_stb", v), stb_cnt - s0, vecs[v].stb);
            chk($sformatf("vec%0d_regs", v), regs, vecs[v].regs);
            chk($sformatf("vec%0d_waddr", v), {25'b0, wr_addr}, {25'b0, vecs[v].waddr});
            chk($sformatf("vec%0d_idle_miso", v), {31'b0, miso}, 32'h0);
        end

        // Status change after the header is latched must not reach the byte in flight.
        spi_frame(16'h4100, 16, 9, 32'h1122993C, -1, rd);
        chk("rd_sample_old", {24'b0, rd}, 32'h33);
        spi_frame(16'h4100, 16, -1, status, -1, rd);
        chk("rd_sample_new", {24'b0, rd}, 32'h99);

        // One SPI clock pulse swallowed while disabled: frame short, no commit.
        s0 = stb_cnt;
        spi_frame(16'h810F, 16, -1, status, 4, rd);
        chk("ena_drop_stb", stb_cnt - s0, 0);
        chk("ena_drop_regs", regs, 32'hC366A512);
        s0 = stb_cnt;
        spi_frame(16'h810F, 16, -1, status, -1, rd);
        chk("ena_after_rd", {24'b0, rd}, 32'hA5);
        chk("ena_after_stb", stb_cnt - s0, 1);
        chk("ena_after_regs", regs, 32'hC3660F12);
        chk("ena_after_waddr", {25'b0, wr_addr}, 32'h01);

        // Reset in the middle of a readback of 0xC3.
        @(negedge clk) cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            mosi = (i == 6 || i == 7) ? 1'b1 : 1'b0;
            repeat (HP) @(negedge clk);
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HP) @(negedge clk);
        chk("pre_reset_miso", {31'b0, miso}, 32'h1);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_reset_regs", regs, 32'h0);
        chk("mid_reset_miso", {31'b0, miso}, 32'h0);
        chk("mid_reset_stb", {31'b0, wr_stb}, 32'h0);
        chk("mid_reset_waddr", {25'b0, wr_addr}, 32'h0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
        s0 = stb_cnt;
        spi_frame(16'h8155, 16, -1, status, -1, rd);
        chk("post_reset_rd", {24'b0, rd}, 32'h00);
        chk("post_reset_stb", stb_cnt - s0, 1);
        chk("post_reset_regs", regs, 32'h00005500);
        chk("post_reset_waddr", {25'b0, wr_addr}, 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
